// File: rtl/glorb_pkg.sv
// rtl/glorb_pkg.sv - shared width constants and loader state encoding for the 8-bit core
// Contents:
//   IM_DEPTH, IM_ADDR_W, WORD_W  instruction memory geometry shared by Pc/Im/Rf and the loader
//   loader_state_t               program loader FSM states
//   len_ok()                     frame length legality check (1..IM_DEPTH)
package glorb_pkg;

    localparam int IM_DEPTH  = 16;
    localparam int IM_ADDR_W = 4;
    localparam int WORD_W    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        FLUSH = 3'd3,
        RUN   = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

    // A frame must carry at least one instruction and no more than fit in Im.
    function automatic logic len_ok(input logic [WORD_W-1:0] len, input int depth);
        logic [WORD_W-1:0] max_len;
        max_len = WORD_W'(depth);
        return (len != '0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader feeding the instruction memory and core start line
// Optional feature macro: CHECKSUM_EN (adds trailing XOR checksum byte and CHECK state).
// Frame: LEN byte, LEN instruction bytes, then (CHECKSUM_EN) one XOR checksum byte.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   stream byte present
//   in_data   in   stream byte
//   in_ready  out  loader accepts byte (combinational)
//   reload    in   synchronous abort/restart to IDLE
//   im_we     out  instruction memory write enable (one-cycle pulse per byte)
//   im_addr   out  instruction memory write address
//   im_wdata  out  instruction memory write data
//   start     out  core run enable, high only in RUN
//   busy      out  high in LOAD/CHECK/FLUSH
//   err       out  high in ERR (bad LEN or checksum mismatch)
module prog_loader
    import glorb_pkg::*;
#(
    parameter int DEPTH  = IM_DEPTH,
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              start,
    output logic              busy,
    output logic              err
);

    // One extra bit so count can reach DEPTH without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    loader_state_t    state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_q;
    logic             transfer;
    logic             last_byte;

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    // reload wins over a simultaneous in_valid: the byte is refused rather than half-consumed.
    assign in_ready = ((state == IDLE) || (state == LOAD) || (state == CHECK)) && !reload;
    assign transfer = in_valid && in_ready;
    assign last_byte = (count == (len_q - CNT_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            len_q    <= '0;
`ifdef CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse; only an accepted LOAD byte re-arms it.
            im_we <= 1'b0;

            if (reload) begin
                state <= IDLE;
                start <= 1'b0;
                err   <= 1'b0;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (transfer) begin
                            if (len_ok(in_data, DEPTH)) begin
                                len_q <= in_data[CNT_W-1:0];
                                count <= '0;
`ifdef CHECKSUM_EN
                                acc   <= '0;
`endif
                                busy  <= 1'b1;
                                state <= LOAD;
                            end else begin
                                err   <= 1'b1;
                                state <= ERR;
                            end
                        end
                    end

                    LOAD: begin
                        if (transfer) begin
                            im_we    <= 1'b1;
                            im_addr  <= count[ADDR_W-1:0];
                            im_wdata <= in_data;
                            count    <= count + CNT_ONE;
`ifdef CHECKSUM_EN
                            acc      <= acc ^ in_data;
                            if (last_byte) begin
                                state <= CHECK;
                            end
`else
                            if (last_byte) begin
                                state <= FLUSH;
                            end
`endif
                        end
                    end

`ifdef CHECKSUM_EN
                    CHECK: begin
                        if (transfer) begin
                            if (in_data == acc) begin
                                state <= FLUSH;
                            end else begin
                                busy  <= 1'b0;
                                err   <= 1'b1;
                                state <= ERR;
                            end
                        end
                    end
`endif

                    // Gives the final im_we pulse its cycle before the core is released.
                    FLUSH: begin
                        busy  <= 1'b0;
                        start <= 1'b1;
                        state <= RUN;
                    end

                    RUN: begin
                        start <= 1'b1;
                    end

                    ERR: begin
                        err   <= 1'b1;
                        start <= 1'b0;
                    end

                    default: begin
                        busy  <= 1'b0;
                        start <= 1'b0;
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader (optional CHECKSUM_EN frames)
module tb_prog_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       reload;
    logic       im_we;
    logic [3:0] im_addr;
    logic [7:0] im_wdata;
    logic       start;
    logic       busy;
    logic       err;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reload   (reload),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .start    (start),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && im_we) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h with no write expected at %0t",
                         im_addr, im_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                if (im_addr !== e.addr || im_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h at %0t",
                             im_addr, im_wdata, e.addr, e.data, $time);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input bit wr, input logic [3:0] a);
        int  n;
        bit  rdy;
        n   = 0;
        rdy = 1'b0;
        if (wr) exp_q.push_back('{addr: a, data: d});
        in_valid = 1'b1;
        in_data  = d;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h not accepted, got in_ready=0 expected 1", d);
        end
    endtask

    task automatic do_reload(input string name);
        reload = 1'b1;
        #1;
        check({name, "_in_ready_during_reload"}, in_ready, 0);
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        check({name, "_err_after_reload"}, err, 0);
        check({name, "_start_after_reload"}, start, 0);
        check({name, "_in_ready_after_reload"}, in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, start, 1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;

        // Reset state
        #12;
        check("rst_im_we", im_we, 0);
        check("rst_im_addr", im_addr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame 03 A1 B2 C3, back to back
        send_byte(8'h03, 0, 4'h0);
        send_byte(8'hA1, 1, 4'h0);
        send_byte(8'hB2, 1, 4'h1);
        send_byte(8'hC3, 1, 4'h2);
`ifdef CHECKSUM_EN
        send_byte(8'hD0, 0, 4'h0);
`endif
        @(negedge clk);
        check("t1_flush_busy", busy, 1);
        check("t1_flush_start", start, 0);
        check("t1_flush_in_ready", in_ready, 0);
        @(negedge clk);
        check("t1_run_start", start, 1);
        check("t1_run_busy", busy, 0);
        check("t1_queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        do_reload("t1");

        // Bad LEN 00 and 11
        send_byte(8'h00, 0, 4'h0);
        @(negedge clk);
        check("len00_err", err, 1);
        check("len00_start", start, 0);
        check("len00_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        do_reload("len00");
        send_byte(8'h11, 0, 4'h0);
        @(negedge clk);
        check("len11_err", err, 1);
        check("len11_start", start, 0);
        check("len11_busy", busy, 0);
        @(posedge clk);
        #1;
        do_reload("len11");

`ifdef CHECKSUM_EN
        // Good and bad checksum
        send_byte(8'h02, 0, 4'h0);
        send_byte(8'h10, 1, 4'h0);
        send_byte(8'h22, 1, 4'h1);
        send_byte(8'h32, 0, 4'h0);
        wait_start("csum_good_start");
        check("csum_good_err", err, 0);
        do_reload("csum_good");
        send_byte(8'h02, 0, 4'h0);
        send_byte(8'h10, 1, 4'h0);
        send_byte(8'h22, 1, 4'h1);
        send_byte(8'h33, 0, 4'h0);
        @(negedge clk);
        check("csum_bad_err", err, 1);
        check("csum_bad_start", start, 0);
        check("csum_bad_queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        do_reload("csum_bad");
`endif

        // Full-depth frame with a one-cycle gap after every byte
        send_byte(8'h10, 0, 4'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h40 + 8'(i), 1, 4'(i));
            @(posedge clk);
            #1;
        end
`ifdef CHECKSUM_EN
        send_byte(8'h00, 0, 4'h0);
`endif
        wait_start("gap16_start");
        @(posedge clk);
        #1;
        do_reload("gap16");

        // reload mid-LOAD with a byte on offer
        send_byte(8'h04, 0, 4'h0);
        send_byte(8'h11, 1, 4'h0);
        send_byte(8'h22, 1, 4'h1);
        in_valid = 1'b1;
        in_data  = 8'h99;
        reload   = 1'b1;
        #1;
        check("midload_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midload_busy_cleared", busy, 0);
        check("midload_im_we", im_we, 0);
        @(posedge clk);
        #1;
        send_byte(8'h02, 0, 4'h0);
        send_byte(8'h55, 1, 4'h0);
        send_byte(8'h66, 1, 4'h1);
`ifdef CHECKSUM_EN
        send_byte(8'h33, 0, 4'h0);
`endif
        wait_start("midload_restart_start");
        @(posedge clk);
        #1;
        do_reload("midload");

        // Async rst between edges while a write is pending
        send_byte(8'h03, 0, 4'h0);
        send_byte(8'h77, 1, 4'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h88;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("async_pre_im_we", im_we, 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_im_we", im_we, 0);
        check("async_busy", busy, 0);
        check("async_start", start, 0);
        check("async_im_addr", im_addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("async_start_stays_low", start, 0);
        end
        check("async_in_ready", in_ready, 1);
        check("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
